tlb_ptw_arbiter: RTL and testbench
==================================

Name: tlb_ptw_arbiter

Overview:
- Shares a single page-table walker (PTW) between NUM_REQ TLBs, e.g. port 0 = I-TLB and port 1 = D-TLB.
- Round-robin arbitration among pending miss requests. The grant is locked from request acceptance until the PTW response returns, and each response is routed back to its owner only.
- Sits between the TLB instances and the PTW. Broadcasts invalidate and status to every TLB.

Parameters:
- NUM_REQ, 2, number of TLB requesters (legal range 2..4).
- REQ_IDX_SIZE, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- tlb_ptw_comm_i  in  tlb_ptw_comm_t[NUM_REQ]  per-TLB request (req.valid, vpn, asid, prv, store, fetch)
- ptw_tlb_comm_o  out  ptw_tlb_comm_t[NUM_REQ]  per-TLB ptw_ready, resp, invalidate_tlb, ptw_status
- tlb_ptw_comm_o  out  tlb_ptw_comm_t  muxed request to the PTW
- ptw_tlb_comm_i  in  ptw_tlb_comm_t  PTW ready, response, invalidate, status
- owner_o  out  REQ_IDX_SIZE  current/last granted port (debug)
- pmu_ptw_conflict_o  out  1  pulses 1 cycle when the PTW is busy or granted elsewhere while another port's req.valid=1

Behaviour:
- Reset: state=IDLE, owner=0, rr_ptr=0 (port 0 has top priority). All outputs are 0 except the broadcast fields, which stay combinationally forwarded.
- Broadcast, always and in every state:
  - ptw_tlb_comm_o[i].invalidate_tlb = ptw_tlb_comm_i.invalidate_tlb
  - ptw_tlb_comm_o[i].ptw_status = ptw_tlb_comm_i.ptw_status
- The FSM uses 3 states: IDLE, HOLD, WAIT_RESP.
- IDLE:
  - Select winner = first port with req.valid=1, scanning from rr_ptr upward with wrap-around.
  - Forward the winner's req combinationally to tlb_ptw_comm_o in the same cycle, so there is zero added latency.
  - ptw_tlb_comm_o[winner].ptw_ready = ptw_tlb_comm_i.ptw_ready; every other port sees ptw_ready=0.
  - If the PTW is ready: owner<=winner, go to WAIT_RESP. Otherwise: owner<=winner, go to HOLD.
  - If no port is valid: tlb_ptw_comm_o.req='0 and the state is unchanged.
- HOLD:
  - The grant stays locked on owner; the owner's req is forwarded and ready is routed to the owner only.
  - Owner ready=1 → WAIT_RESP.
  - Owner drops req.valid (TLB cancelled on invalidate) → IDLE, rr_ptr unchanged.
  - Ready has priority if ready=1 and the drop occur together; the drop cannot legally coincide with a handshake.
- WAIT_RESP:
  - tlb_ptw_comm_o.req='0. ptw_tlb_comm_i.resp is copied to the owner only; every other port's resp.valid=0.
  - On resp.valid: go to IDLE and set rr_ptr<=owner+1 (mod NUM_REQ).
  - A new request in the same cycle as resp.valid is not granted until the next cycle (IDLE).
  - invalidate_tlb in WAIT_RESP does not change state; the response is still delivered, and the TLB discards it itself.
- resp.valid outside WAIT_RESP is dropped (not routed anywhere); the bench flags it as a protocol error.
- Non-owner ports stay pending: their req.valid is held by the TLB FSM and is never acknowledged until they are granted.
- Fairness: with all ports continuously requesting, each port is granted at most once every NUM_REQ walks.
- pmu_ptw_conflict_o = (state!=IDLE, or (state==IDLE and winner≠i)) for any port i≠owner/winner with req.valid=1, restricted to IDLE or HOLD cycles where the losing request is new. Simplified rule: pulses on each cycle in IDLE where ≥2 ports are valid, plus the first cycle a non-owner asserts req.valid while state≠IDLE.
- An asynchronous reset mid-walk returns the block to IDLE immediately. The PTW is reset by the same rstn_i.

Decomposition:
- mmu_pkg: add the arb_state_t enum (IDLE, HOLD, WAIT_RESP) and the constants for I-TLB/D-TLB port indices. tlb_ptw_comm_t and ptw_tlb_comm_t are reused unchanged.
- One sub-module, rr_arbiter (NUM_REQ): inputs req_i, rr_ptr_i; outputs gnt_idx_o, gnt_valid_o. Purely combinational priority rotate.

Test Plan:
- Single port: port1 req vpn=0x12345, PTW ready the same cycle, resp 3 cycles later → PTW sees vpn 0x12345 in cycle 0, port1 receives resp.valid in cycle 3, port0 never sees ready/resp, owner_o=1, rr_ptr=0.
- Simultaneous requests after reset: port0 vpn=0xA, port1 vpn=0xB → port0 is walked first. Port1 is forwarded in the cycle after port0's resp and completes second. pmu_ptw_conflict_o pulses once at cycle 0.
- Back-to-back fairness: both ports hold req.valid continuously for 6 walks → grant order 0,1,0,1,0,1.
- PTW not ready: port0 req with ptw_ready=0 for 4 cycles, then port1 req arrives → stays in HOLD on port0. Port1 gets ready only after port0's resp.
- Cancel in HOLD: port0 req, ptw_ready=0, invalidate_tlb=1 and port0 drops req → returns to IDLE. A pending port1 req is granted the next cycle and invalidate reaches both ports.
- Invalidate in WAIT_RESP: invalidate_tlb pulse mid-walk → both ports see the invalidate. The owner still receives resp.valid and the other port does not.

Source files
------------

// File: rtl/mmu_pkg.sv
// MMU shared types: TLB<->PTW bundles and
// the PTW arbiter state encoding.
package mmu_pkg;

  localparam int ITLB_IDX = 0;
  localparam int DTLB_IDX = 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_RESP
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [26:0] vpn;
    logic [8:0]  asid;
    logic [1:0]  prv;
    logic        store;
    logic        fetch;
  } tlb_req_t;

  typedef struct packed {
    tlb_req_t req;
  } tlb_ptw_comm_t;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [43:0] ppn;
    logic [7:0]  perm;
  } ptw_resp_t;

  typedef struct packed {
    logic [1:0] prv;
    logic       sum;
    logic       mxr;
  } ptw_status_t;

  typedef struct packed {
    logic        ptw_ready;
    ptw_resp_t   resp;
    logic        invalidate_tlb;
    ptw_status_t ptw_status;
  } ptw_tlb_comm_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set
// request at or after rr_ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int REQ_IDX_SIZE = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [REQ_IDX_SIZE-1:0] rr_ptr_i,
  output logic [REQ_IDX_SIZE-1:0] gnt_idx_o,
  output logic                    gnt_valid_o
);

  logic [REQ_IDX_SIZE-1:0] idx;

  // Scan farthest-first so the nearest hit wins
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = REQ_IDX_SIZE'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_idx_o   = idx;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_ptw_arbiter.sv
// Shares one page-table walker among several
// TLBs with a locked round-robin grant.
module tlb_ptw_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int REQ_IDX_SIZE = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  tlb_ptw_comm_t           tlb_ptw_comm_i [NUM_REQ],
  output ptw_tlb_comm_t           ptw_tlb_comm_o [NUM_REQ],
  output tlb_ptw_comm_t           tlb_ptw_comm_o,
  input  ptw_tlb_comm_t           ptw_tlb_comm_i,
  output logic [REQ_IDX_SIZE-1:0] owner_o,
  output logic                    pmu_ptw_conflict_o
);

  arb_state_t              state_q;
  logic [REQ_IDX_SIZE-1:0] owner_q;
  logic [REQ_IDX_SIZE-1:0] rr_ptr_q;
  logic [REQ_IDX_SIZE-1:0] rr_ptr_d;
  logic [NUM_REQ-1:0]      vld;
  logic [NUM_REQ-1:0]      vld_q;
  logic [NUM_REQ-1:0]      own_oh;
  logic [REQ_IDX_SIZE-1:0] gnt_idx;
  logic                    gnt_valid;
  logic [REQ_IDX_SIZE-1:0] sel;
  logic                    sel_act;

  // Gather per-port request valids
  always_comb begin
    vld    = '0;
    own_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      vld[i] = tlb_ptw_comm_i[i].req.valid;
    end
    own_oh[owner_q] = 1'b1;
  end

  rr_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .REQ_IDX_SIZE (REQ_IDX_SIZE)
  ) u_rr (
    .req_i       (vld),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Pick the port that currently drives the PTW
  always_comb begin
    sel      = (state_q == HOLD) ? owner_q : gnt_idx;
    sel_act  = (state_q == HOLD) ||
               ((state_q == IDLE) && gnt_valid);
    rr_ptr_d = REQ_IDX_SIZE'((int'(owner_q) + 1) % NUM_REQ);
  end

  // Request mux, ready/resp routing, broadcasts
  always_comb begin
    tlb_ptw_comm_o = '0;
    if (sel_act) tlb_ptw_comm_o = tlb_ptw_comm_i[sel];
    for (int i = 0; i < NUM_REQ; i++) begin
      ptw_tlb_comm_o[i] = '0;
      ptw_tlb_comm_o[i].invalidate_tlb =
        ptw_tlb_comm_i.invalidate_tlb;
      ptw_tlb_comm_o[i].ptw_status =
        ptw_tlb_comm_i.ptw_status;
      ptw_tlb_comm_o[i].ptw_ready =
        sel_act && (sel == REQ_IDX_SIZE'(i)) &&
        ptw_tlb_comm_i.ptw_ready;
      if ((state_q == WAIT_RESP) &&
          (owner_q == REQ_IDX_SIZE'(i)))
        ptw_tlb_comm_o[i].resp = ptw_tlb_comm_i.resp;
    end
  end

  // Conflict: contention in IDLE, or a new loser while busy
  always_comb begin
    if (state_q == IDLE)
      pmu_ptw_conflict_o = ($countones(vld) > 1);
    else
      pmu_ptw_conflict_o = |(vld & ~vld_q & ~own_oh);
  end

  assign owner_o = owner_q;

  // Grant FSM: lock on owner until the walk returns
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      vld_q <= vld;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_idx;
            state_q <= ptw_tlb_comm_i.ptw_ready ?
                       WAIT_RESP : HOLD;
          end
        end
        HOLD: begin
          if (ptw_tlb_comm_i.ptw_ready)
            state_q <= WAIT_RESP;
          else if (!vld[owner_q])
            state_q <= IDLE;
        end
        WAIT_RESP: begin
          if (ptw_tlb_comm_i.resp.valid) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ptw_arbiter.sv
// Randomized bench for tlb_ptw_arbiter against a
// walk-level model of the shared PTW.
module tb_tlb_ptw_arbiter;
  import mmu_pkg::*;

  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  tlb_ptw_comm_t req_in [NR];
  ptw_tlb_comm_t tlb_out [NR];
  tlb_ptw_comm_t ptw_req;
  ptw_tlb_comm_t ptw_in;
  logic [0:0]    owner;
  logic          pmu;

  int n_chk = 0;
  int n_pass = 0;

  // model: walk in flight, grant locked, owner, next start
  bit          m_busy;
  bit          m_locked;
  int          m_owner;
  int          m_start;
  logic [NR-1:0] m_prev;
  int          g_ack;
  int          g_resp;

  int st [NR];
  int cnt;

  tlb_ptw_arbiter #(.NUM_REQ(NR)) dut (
    .clk_i              (clk),
    .rstn_i             (rst_n),
    .tlb_ptw_comm_i     (req_in),
    .ptw_tlb_comm_o     (tlb_out),
    .tlb_ptw_comm_o     (ptw_req),
    .ptw_tlb_comm_i     (ptw_in),
    .owner_o            (owner),
    .pmu_ptw_conflict_o (pmu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_locked = 0; m_owner = 0;
    m_start = 0; m_prev = '0;
    for (int i = 0; i < NR; i++) st[i] = 0;
    cnt = 0;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NR; i++) req_in[i] = '0;
    ptw_in = '0;
  endtask

  // check one cycle at negedge, then advance model
  task automatic step();
    logic [NR-1:0] v;
    logic [NR-1:0] rose;
    logic [NR-1:0] erdy;
    tlb_ptw_comm_t er;
    logic epmu;
    int w;
    int nv;
    int cand;
    @(negedge clk);
    v = '0; nv = 0; w = -1;
    for (int i = 0; i < NR; i++) begin
      v[i] = req_in[i].req.valid;
      nv += int'(v[i]);
    end
    for (int k = 0; k < NR; k++) begin
      int p;
      p = (m_start + k) % NR;
      if (w < 0 && v[p]) w = p;
    end
    g_ack = -1; g_resp = -1; erdy = '0; er = '0;
    if (m_busy) begin
      if (ptw_in.resp.valid) g_resp = m_owner;
    end else begin
      cand = m_locked ? m_owner : w;
      if (cand >= 0) begin
        er = req_in[cand];
        erdy[cand] = ptw_in.ptw_ready;
      end
    end
    rose = v & ~m_prev;
    rose[m_owner] = 1'b0;
    epmu = (!m_busy && !m_locked) ? (nv >= 2) : |rose;
    chk("owner", 64'(owner), 64'(m_owner));
    chk("ptw_req", 64'(ptw_req), 64'(er));
    chk("pmu", 64'(pmu), 64'(epmu));
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rdy%0d", i),
          64'(tlb_out[i].ptw_ready), 64'(erdy[i]));
      chk($sformatf("rspv%0d", i),
          64'(tlb_out[i].resp.valid), 64'(g_resp == i));
      if (g_resp == i)
        chk($sformatf("rsp%0d", i),
            64'(tlb_out[i].resp), 64'(ptw_in.resp));
      chk($sformatf("inv%0d", i),
          64'(tlb_out[i].invalidate_tlb),
          64'(ptw_in.invalidate_tlb));
      chk($sformatf("stat%0d", i),
          64'(tlb_out[i].ptw_status),
          64'(ptw_in.ptw_status));
    end
    if (m_busy) begin
      if (g_resp >= 0) begin
        m_busy = 0;
        m_start = (m_owner + 1) % NR;
      end
    end else if (m_locked) begin
      if (ptw_in.ptw_ready) begin
        m_busy = 1; m_locked = 0; g_ack = m_owner;
      end else if (!v[m_owner]) m_locked = 0;
    end else if (w >= 0) begin
      m_owner = w;
      if (ptw_in.ptw_ready) begin
        m_busy = 1; g_ack = w;
      end else m_locked = 1;
    end
    m_prev = v;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic vl,
                         input logic [26:0] vpn);
    req_in[p].req.valid = vl;
    req_in[p].req.vpn   = vpn;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    ptw_in.invalidate_tlb = 1'b1;
    ptw_in.ptw_status = 4'hA;
    #12;
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_req", 64'(ptw_req), 64'd0);
    chk("rst_rdy0", 64'(tlb_out[0].ptw_ready), 64'd0);
    chk("rst_inv1", 64'(tlb_out[1].invalidate_tlb), 64'd1);
    chk("rst_stat0", 64'(tlb_out[0].ptw_status), 64'hA);
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single port 1 walk, resp 3 cycles later
    set_req(1, 1'b1, 27'h12345);
    ptw_in.ptw_ready = 1'b1;
    step();
    set_req(1, 1'b0, 27'h12345);
    ptw_in.ptw_ready = 1'b0;
    step(); step();
    ptw_in.resp.valid = 1'b1;
    ptw_in.resp.ppn = 44'h777;
    step();
    ptw_in.resp = '0;

    // simultaneous requests, then port 1 second
    set_req(0, 1'b1, 27'hA);
    set_req(1, 1'b1, 27'hB);
    ptw_in.ptw_ready = 1'b1;
    step();
    set_req(0, 1'b0, 27'hA);
    step();
    ptw_in.resp.valid = 1'b1;
    step();
    ptw_in.resp.valid = 1'b0;
    step();
    set_req(1, 1'b0, 27'hB);
    ptw_in.ptw_ready = 1'b0;
    ptw_in.resp.valid = 1'b1;
    step();
    ptw_in.resp.valid = 1'b0;

    // cancel in HOLD while port 1 waits
    set_req(0, 1'b1, 27'h5);
    step(); step();
    set_req(1, 1'b1, 27'h6);
    step();
    ptw_in.invalidate_tlb = 1'b1;
    set_req(0, 1'b0, 27'h5);
    step();
    ptw_in.invalidate_tlb = 1'b0;
    ptw_in.ptw_ready = 1'b1;
    step();
    set_req(1, 1'b0, 27'h6);
    ptw_in.ptw_ready = 1'b0;
    ptw_in.invalidate_tlb = 1'b1;
    step();
    ptw_in.invalidate_tlb = 1'b0;
    ptw_in.resp.valid = 1'b1;
    step();
    clear_inputs();

    // randomized traffic with a mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("arst_owner", 64'(owner), 64'd0);
        chk("arst_req", 64'(ptw_req), 64'd0);
        chk("arst_rsp1", 64'(tlb_out[1].resp.valid), 64'd0);
        model_reset();
        g_ack = -1; g_resp = -1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
      end
      for (int i = 0; i < NR; i++) begin
        if (g_ack == i) st[i] = 2;
        if (g_resp == i) st[i] = 0;
      end
      if (g_ack >= 0) cnt = int'($urandom_range(1, 4));
      ptw_in.ptw_ready = ($urandom % 3) != 0;
      ptw_in.invalidate_tlb = ($urandom % 12) == 0;
      ptw_in.ptw_status = 4'($urandom);
      ptw_in.resp.ppn = 44'($urandom);
      ptw_in.resp.perm = 8'($urandom);
      ptw_in.resp.error = 1'($urandom);
      ptw_in.resp.valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ptw_in.resp.valid = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
        if (st[i] == 0 && ($urandom % 3) == 0) begin
          st[i] = 1;
          req_in[i].req = 41'({$urandom, $urandom});
        end else if (st[i] == 1 && ptw_in.invalidate_tlb &&
                     !ptw_in.ptw_ready && ($urandom % 2) == 0)
          st[i] = 0;
        req_in[i].req.valid = (st[i] == 1);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
